// File: rtl/baud_tick_if.sv
// baud_tick_if: control/status bundle between a baud tick generator and its user
//   enable, clear, load, divisor : driven by the master (controller)
//   s_tick, bit_tick, div_err    : one-cycle pulses driven by the generator
//   div_count, ovs_count         : live counter values driven by the generator
interface baud_tick_if #(
    parameter int DIV_BITS = 11,
    parameter int OVS_BITS = 4
);
    logic                enable;
    logic                clear;
    logic                load;
    logic [DIV_BITS-1:0] divisor;
    logic                s_tick;
    logic                bit_tick;
    logic                div_err;
    logic [DIV_BITS-1:0] div_count;
    logic [OVS_BITS-1:0] ovs_count;
    modport master (
        output enable, clear, load, divisor,
        input  s_tick, bit_tick, div_err, div_count, ovs_count
    );
    modport slave (
        input  enable, clear, load, divisor,
        output s_tick, bit_tick, div_err, div_count, ovs_count
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable sample-tick divider with an oversample bit-tick stage
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : enable/clear/load/divisor in; s_tick/bit_tick/div_err/div_count/ovs_count out
module baud_tick_gen #(
    parameter int DIV_BITS    = 11,
    parameter int DEFAULT_DIV = 651,
    parameter int OVS         = 16,
    parameter int OVS_BITS    = 4
) (
    input logic       clk,
    input logic       reset_n,
    baud_tick_if.slave bus
);
    logic [DIV_BITS-1:0] div_reg;
    logic [DIV_BITS-1:0] div_count;
    logic [OVS_BITS-1:0] ovs_count;
    logic                div_err;
    logic                div_end;
    logic                ovs_end;
    logic                load_ok;
    logic                restart;
    logic                s_tick;
    always_comb begin
        div_end = div_count == div_reg - DIV_BITS'(1);
        ovs_end = ovs_count == OVS_BITS'(OVS - 1);
        load_ok = bus.load && (bus.divisor >= DIV_BITS'(2));
        restart = bus.clear || load_ok;
        // any load, even a rejected one, swallows the tick of its cycle
        s_tick  = reset_n && bus.enable && div_end && !bus.clear && !bus.load;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg   <= DIV_BITS'(DEFAULT_DIV);
            div_count <= '0;
            ovs_count <= '0;
            div_err   <= 1'b0;
        end else begin
            div_err <= bus.load && !load_ok;
            if (load_ok) div_reg <= bus.divisor;
            if (restart) begin
                div_count <= '0;
                ovs_count <= '0;
            end else if (bus.enable) begin
                // a rejected load lets the divider wrap but the suppressed tick does not advance ovs
                div_count <= div_end ? '0 : div_count + DIV_BITS'(1);
                if (s_tick) ovs_count <= ovs_end ? '0 : ovs_count + OVS_BITS'(1);
            end
        end
    end
    assign bus.s_tick    = s_tick;
    assign bus.bit_tick  = s_tick && ovs_end;
    assign bus.div_err   = div_err;
    assign bus.div_count = div_count;
    assign bus.ovs_count = ovs_count;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scoreboard bench for baud_tick_gen against a cycle reference model
module tb_baud_tick_gen;
    typedef struct {
        int s_tick;
        int bit_tick;
        int div_err;
        int div_count;
        int ovs_count;
    } exp_t;
    logic clk = 1'b1;
    logic reset_n = 1'b1;
    baud_tick_if #(.DIV_BITS(11), .OVS_BITS(4)) bus ();
    baud_tick_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    exp_t sb[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int m_div = 651;
    int m_dc = 0;
    int m_oc = 0;
    int m_err = 0;
    int cyc = 0;
    int s_cnt = 0;
    int b_cnt = 0;
    int first = -1;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // push expected outputs for this cycle, then advance the model across the coming edge
    task automatic step();
        exp_t e;
        int st;
        if (!reset_n) begin
            m_div = 651; m_dc = 0; m_oc = 0; m_err = 0;
        end
        st = (reset_n && bus.enable && m_dc == m_div - 1 && !bus.clear && !bus.load) ? 1 : 0;
        e.s_tick = st;
        e.bit_tick = (st == 1 && m_oc == 15) ? 1 : 0;
        e.div_err = m_err;
        e.div_count = m_dc;
        e.ovs_count = m_oc;
        sb.push_back(e);
        if (reset_n) begin
            m_err = (bus.load && bus.divisor < 2) ? 1 : 0;
            if (bus.load && bus.divisor >= 2) begin
                m_div = int'(bus.divisor); m_dc = 0; m_oc = 0;
            end else if (bus.clear) begin
                m_dc = 0; m_oc = 0;
            end else if (bus.enable) begin
                if (st == 1) m_oc = (m_oc + 1) % 16;
                m_dc = (m_dc + 1) % m_div;
            end
        end
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input bit en, input bit clr, input bit ld, input int dv, input int n);
        bus.enable = en;
        bus.clear = clr;
        bus.load = ld;
        bus.divisor = 11'(dv);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic zero_stats();
        cyc = 0; s_cnt = 0; b_cnt = 0; first = -1;
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("s_tick", int'(bus.s_tick), mon_e.s_tick);
            check("bit_tick", int'(bus.bit_tick), mon_e.bit_tick);
            check("div_err", int'(bus.div_err), mon_e.div_err);
            check("div_count", int'(bus.div_count), mon_e.div_count);
            check("ovs_count", int'(bus.ovs_count), mon_e.ovs_count);
            if (bus.s_tick) begin
                s_cnt++;
                if (first < 0) first = cyc + 1;
            end
            if (bus.bit_tick) b_cnt++;
            cyc++;
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.enable = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.divisor = '0;
        #1 reset_n = 1'b0;
        drive(0, 0, 0, 0, 3);
        check("reset_div_count", int'(bus.div_count), 0);
        check("reset_div_err", int'(bus.div_err), 0);
        // default divisor 651 out of reset
        reset_n = 1'b1;
        zero_stats();
        drive(1, 0, 0, 0, 651 * 3);
        check("t1_first_tick_edge", first, 651);
        check("t1_tick_count", s_cnt, 3);
        // divisor 4: s_tick every 4, bit_tick every 64
        drive(1, 0, 1, 4, 1);
        zero_stats();
        drive(1, 0, 0, 0, 128);
        check("t2_s_count", s_cnt, 32);
        check("t2_bit_count", b_cnt, 2);
        // hold at 2/5 with enable low, then resume
        drive(1, 0, 1, 4, 1);
        drive(1, 0, 0, 0, 22);
        check("t3_dc_before", int'(bus.div_count), 2);
        check("t3_oc_before", int'(bus.ovs_count), 5);
        zero_stats();
        drive(0, 0, 0, 0, 10);
        check("t3_dc_held", int'(bus.div_count), 2);
        check("t3_oc_held", int'(bus.ovs_count), 5);
        check("t3_no_ticks", s_cnt, 0);
        drive(1, 0, 0, 0, 2);
        check("t3_resume_tick", s_cnt, 1);
        // reload mid-count
        drive(1, 0, 1, 8, 1);
        drive(1, 0, 0, 0, 3);
        check("t4_dc_mid", int'(bus.div_count), 3);
        drive(1, 0, 1, 5, 1);
        zero_stats();
        drive(1, 0, 0, 0, 15);
        check("t4_ticks", s_cnt, 3);
        check("t4_first", first, 5);
        // rejected divisors
        drive(1, 0, 1, 1, 1);
        check("t5_err1", int'(bus.div_err), 1);
        drive(1, 0, 0, 0, 2);
        drive(1, 0, 1, 0, 1);
        check("t5_err0", int'(bus.div_err), 1);
        drive(1, 0, 0, 0, 1);
        check("t5_err_clear", int'(bus.div_err), 0);
        for (int i = 0; i < 10 && bus.div_count != 11'd4; i++) drive(1, 0, 0, 0, 1);
        zero_stats();
        drive(1, 0, 1, 0, 1);
        check("t5_suppressed", s_cnt, 0);
        drive(1, 0, 0, 0, 12);
        // load while disabled
        drive(0, 0, 1, 7, 1);
        drive(0, 0, 0, 0, 3);
        zero_stats();
        drive(1, 0, 0, 0, 14);
        check("t5_disabled_load", s_cnt, 2);
        // clear with load, lone clear, clear with rejected load, async reset
        drive(1, 1, 1, 6, 1);
        drive(1, 0, 0, 0, 4);
        drive(1, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 3);
        drive(1, 1, 1, 0, 1);
        drive(1, 0, 0, 0, 4);
        reset_n = 1'b0;
        #1;
        check("t6_async_dc", int'(bus.div_count), 0);
        drive(1, 0, 0, 0, 2);
        reset_n = 1'b1;
        zero_stats();
        drive(1, 0, 0, 0, 660);
        check("t6_default_restored", first, 651);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
